// File: rtl/pe_stream_hub_if.sv
// Bundle of PE-side links and router-side streams for pe_stream_hub.
// The hub connects through the slave modport, and its environment uses the master modport.
interface pe_stream_hub_if #(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int ID_WIDTH = $clog2(NUM_PE);

  logic [NUM_PE*DATA_WIDTH-1:0] pe_datain;
  logic [NUM_PE-1:0]            pe_datain_valid;
  logic [NUM_PE-1:0]            pe_datain_accept;
  logic [NUM_PE*DATA_WIDTH-1:0] pe_dataout;
  logic [NUM_PE-1:0]            pe_dataout_valid;
  logic [NUM_PE-1:0]            pe_dataout_accept;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [ID_WIDTH-1:0]          m_pe_id;
  logic                         m_valid;
  logic                         m_accept;
  logic [DATA_WIDTH-1:0]        s_data;
  logic [ID_WIDTH-1:0]          s_dest;
  logic                         s_bcast;
  logic                         s_valid;
  logic                         s_accept;
  logic                         err_bad_dest;

  modport slave (
    input  pe_datain, pe_datain_valid, pe_dataout_accept, m_accept,
           s_data, s_dest, s_bcast, s_valid,
    output pe_datain_accept, pe_dataout, pe_dataout_valid,
           m_data, m_pe_id, m_valid, s_accept, err_bad_dest
  );

  modport master (
    output pe_datain, pe_datain_valid, pe_dataout_accept, m_accept,
           s_data, s_dest, s_bcast, s_valid,
    input  pe_datain_accept, pe_dataout, pe_dataout_valid,
           m_data, m_pe_id, m_valid, s_accept, err_bad_dest
  );
endinterface

// File: rtl/pe_stream_hub.sv
// PE-side stream hub: per-PE ingress FIFOs merged by an arbiter into one tagged stream,
// and a router stream delivered to PEs by unicast or broadcast through per-PE output registers.
module pe_stream_hub #(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input logic          clk,
  input logic          rst_n,
  pe_stream_hub_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_PE);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  logic [DATA_WIDTH-1:0] fifo_mem [NUM_PE][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr   [NUM_PE];
  logic [PTR_W-1:0]      rd_ptr   [NUM_PE];
  logic [CNT_W-1:0]      count    [NUM_PE];

  logic [NUM_PE-1:0]     push, pop, not_empty, in_accept;
  logic                  load_en, grant_valid;
  logic [ID_WIDTH-1:0]   grant_id, rr_ptr;
  logic [DATA_WIDTH-1:0] grant_data;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [ID_WIDTH-1:0]   m_pe_id_q;

  logic [DATA_WIDTH-1:0]        out_data [NUM_PE];
  logic [NUM_PE-1:0]            out_valid, out_free, out_load;
  logic [NUM_PE*DATA_WIDTH-1:0] dataout_flat;
  logic [ID_WIDTH:0]            dest_ext;
  logic                         bad_dest, dest_free, s_accept_c, s_fire, err_q;

  // Accept depends only on FIFO occupancy, never on m_accept, so there is no full-bypass path.
  always_comb begin
    load_en = !m_valid_q || bus.m_accept;
    for (int i = 0; i < NUM_PE; i++) begin
      in_accept[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      not_empty[i] = (count[i] != '0);
      push[i]      = bus.pe_datain_valid[i] && in_accept[i];
      pop[i]       = load_en && grant_valid && (grant_id == ID_WIDTH'(i));
    end
  end

  assign bus.pe_datain_accept = in_accept;

  // Round-robin: lowest non-empty index above the last grant, else lowest at or below it.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PE-1; i >= 0; i--) begin
        if (not_empty[i] && (ID_WIDTH'(i) <= rr_ptr)) begin
          grant_valid = 1'b1;
          grant_id    = ID_WIDTH'(i);
        end
      end
      for (int i = NUM_PE-1; i >= 0; i--) begin
        if (not_empty[i] && (ID_WIDTH'(i) > rr_ptr)) begin
          grant_valid = 1'b1;
          grant_id    = ID_WIDTH'(i);
        end
      end
    end else begin
      for (int i = NUM_PE-1; i >= 0; i--) begin
        if (not_empty[i]) begin
          grant_valid = 1'b1;
          grant_id    = ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant_id == ID_WIDTH'(i)) grant_data = fifo_mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= bus.pe_datain[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PE; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // The pointer starts at the last PE so that PE0 wins the first round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_pe_id_q <= '0;
      rr_ptr    <= ID_WIDTH'(NUM_PE-1);
    end else if (load_en) begin
      if (grant_valid) begin
        m_valid_q <= 1'b1;
        m_data_q  <= grant_data;
        m_pe_id_q <= grant_id;
        rr_ptr    <= grant_id;
      end else begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_pe_id = m_pe_id_q;

  // The destination is widened by one bit so the range test stays meaningful for any NUM_PE.
  always_comb begin
    dest_ext  = {1'b0, bus.s_dest};
    bad_dest  = !bus.s_bcast && (dest_ext >= (ID_WIDTH+1)'(NUM_PE));
    dest_free = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      out_free[i] = !out_valid[i] || bus.pe_dataout_accept[i];
      if (bus.s_dest == ID_WIDTH'(i)) dest_free = out_free[i];
    end
    if (bus.s_bcast)   s_accept_c = &out_free;
    else if (bad_dest) s_accept_c = 1'b1;
    else               s_accept_c = dest_free;
    s_fire = bus.s_valid && s_accept_c;
    for (int i = 0; i < NUM_PE; i++) begin
      out_load[i] = s_fire && !bad_dest && (bus.s_bcast || (bus.s_dest == ID_WIDTH'(i)));
    end
  end

  assign bus.s_accept = s_accept_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) out_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (out_load[i]) begin
          out_data[i]  <= bus.s_data;
          out_valid[i] <= 1'b1;
        end else if (bus.pe_dataout_accept[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (s_fire && bad_dest) err_q <= 1'b1;
    end
  end

  always_comb begin
    dataout_flat = '0;
    for (int i = 0; i < NUM_PE; i++) dataout_flat[i*DATA_WIDTH +: DATA_WIDTH] = out_data[i];
  end

  assign bus.pe_dataout       = dataout_flat;
  assign bus.pe_dataout_valid = out_valid;
  assign bus.err_bad_dest     = err_q;
endmodule

// File: tb/tb_pe_stream_hub.sv
// Directed bench for pe_stream_hub: round-robin, fixed-priority and 3-PE instances share one clock and reset.
module tb_pe_stream_hub;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pe_stream_hub_if #(.NUM_PE(4), .DATA_WIDTH(DW)) bus_rr ();
  pe_stream_hub_if #(.NUM_PE(4), .DATA_WIDTH(DW)) bus_fp ();
  pe_stream_hub_if #(.NUM_PE(3), .DATA_WIDTH(DW)) bus3 ();

  pe_stream_hub #(.NUM_PE(4), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .ARB_MODE(0))
    dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
  pe_stream_hub #(.NUM_PE(4), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .ARB_MODE(1))
    dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));
  pe_stream_hub #(.NUM_PE(3), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .ARB_MODE(0))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  function automatic logic [63:0] pat(int pe, int seq);
    return {32'hA000_0000 | 32'(pe), 32'(seq)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_rr.pe_datain = '0; bus_rr.pe_datain_valid = '0; bus_rr.pe_dataout_accept = '0;
    bus_rr.m_accept = 1'b0; bus_rr.s_data = '0; bus_rr.s_dest = '0; bus_rr.s_bcast = 1'b0; bus_rr.s_valid = 1'b0;
    bus_fp.pe_datain = '0; bus_fp.pe_datain_valid = '0; bus_fp.pe_dataout_accept = '0;
    bus_fp.m_accept = 1'b0; bus_fp.s_data = '0; bus_fp.s_dest = '0; bus_fp.s_bcast = 1'b0; bus_fp.s_valid = 1'b0;
    bus3.pe_datain = '0; bus3.pe_datain_valid = '0; bus3.pe_dataout_accept = '0;
    bus3.m_accept = 1'b0; bus3.s_data = '0; bus3.s_dest = '0; bus3.s_bcast = 1'b0; bus3.s_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    bus_rr.pe_datain_valid = '1; bus_rr.pe_datain = {4{64'hDEAD_BEEF_0000_0001}};
    bus_rr.s_valid = 1'b1; bus_rr.s_bcast = 1'b1; bus_rr.s_data = 64'h55; bus_rr.m_accept = 1'b1;
    bus3.pe_datain_valid = '1; bus3.pe_datain = {3{64'hCAFE_0000_0000_0002}};
    bus3.s_valid = 1'b1; bus3.s_dest = 2'd3; bus3.m_accept = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({bus_rr.m_valid, bus_rr.m_pe_id, bus_rr.err_bad_dest, bus_rr.pe_dataout_valid} !== 8'h00 ||
        bus_rr.m_data !== 64'h0 || bus_rr.pe_dataout !== 256'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rr_outputs: m_valid=%b m_data=%h id=%0d dout_valid=%b err=%b, required all 0",
               bus_rr.m_valid, bus_rr.m_data, bus_rr.m_pe_id, bus_rr.pe_dataout_valid, bus_rr.err_bad_dest);
    end
    tests_run++;
    if ({bus3.m_valid, bus3.err_bad_dest, bus3.pe_dataout_valid} !== 5'h0 || bus3.m_data !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pe3_outputs: m_valid=%b err=%b dout_valid=%b m_data=%h, required all 0",
               bus3.m_valid, bus3.err_bad_dest, bus3.pe_dataout_valid, bus3.m_data);
    end
    idle_all();
    #2 rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus_rr.pe_datain_accept !== 4'hF || bus3.pe_datain_accept !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_accept: got %b/%b, required 1111/111",
               bus_rr.pe_datain_accept, bus3.pe_datain_accept);
    end
    step();
  endtask

  task automatic test_rr_fairness();
    int seq[4];
    int exp_seq[4];
    int exp_id;
    int beats;
    logic started;
    logic [3:0] acc;
    do_reset();
    exp_id = 0; beats = 0; started = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; exp_seq[i] = 0;
      bus_rr.pe_datain[i*DW +: DW] = pat(i, 0);
    end
    bus_rr.pe_datain_valid = 4'hF;
    bus_rr.m_accept = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = bus_rr.pe_datain_accept;
      if (bus_rr.m_valid) begin
        started = 1'b1;
        tests_run++;
        if (bus_rr.m_pe_id !== 2'(exp_id) || bus_rr.m_data !== pat(exp_id, exp_seq[exp_id])) begin
          tests_failed++;
          $display("[TB] FAIL rr_beat%0d: id=%0d data=%h, required id=%0d data=%h",
                   beats, bus_rr.m_pe_id, bus_rr.m_data, exp_id, pat(exp_id, exp_seq[exp_id]));
        end
        exp_seq[exp_id]++;
        exp_id = (exp_id + 1) % 4;
        beats++;
      end else if (started) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rr_gap: m_valid=0 at cycle %0d, required 1", c);
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          seq[i]++;
          bus_rr.pe_datain[i*DW +: DW] = pat(i, seq[i]);
        end
      end
    end
    tests_run++;
    if (beats != 38) begin
      tests_failed++;
      $display("[TB] FAIL rr_beat_count: got %0d, required 38", beats);
    end
    idle_all();
  endtask

  task automatic test_backpressure();
    int pushed;
    int got;
    logic acc;
    do_reset();
    pushed = 0;
    bus_rr.m_accept = 1'b0;
    bus_rr.pe_datain[2*DW +: DW] = pat(2, 0);
    bus_rr.pe_datain_valid = 4'b0100;
    for (int c = 0; c < 8 && pushed < 5; c++) begin
      acc = bus_rr.pe_datain_accept[2];
      step();
      if (acc) begin
        pushed++;
        bus_rr.pe_datain[2*DW +: DW] = pat(2, pushed);
      end
    end
    tests_run++;
    if (pushed != 5 || bus_rr.pe_datain_accept[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_fill: pushed=%0d accept2=%b, required 5 and 0", pushed, bus_rr.pe_datain_accept[2]);
    end
    repeat (3) step();
    tests_run++;
    if (bus_rr.m_valid !== 1'b1 || bus_rr.m_pe_id !== 2'd2 || bus_rr.m_data !== pat(2, 0) ||
        bus_rr.pe_datain_accept[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall: m_valid=%b id=%0d data=%h accept2=%b, required 1/2/%h/0",
               bus_rr.m_valid, bus_rr.m_pe_id, bus_rr.m_data, bus_rr.pe_datain_accept[2], pat(2, 0));
    end
    bus_rr.pe_datain_valid = 4'b0000;
    bus_rr.m_accept = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus_rr.m_valid) begin
        tests_run++;
        if (bus_rr.m_pe_id !== 2'd2 || bus_rr.m_data !== pat(2, got)) begin
          tests_failed++;
          $display("[TB] FAIL bp_drain%0d: id=%0d data=%h, required 2/%h", got, bus_rr.m_pe_id, bus_rr.m_data, pat(2, got));
        end
        got++;
      end
      step();
    end
    tests_run++;
    if (got != 5 || bus_rr.m_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain_count: got %0d beats m_valid=%b, required 5 and 0", got, bus_rr.m_valid);
    end
    idle_all();
  endtask

  task automatic test_reset_midflight();
    logic seen;
    do_reset();
    bus_rr.m_accept = 1'b0;
    bus_rr.pe_datain_valid = 4'b0010;
    for (int s = 0; s < 3; s++) begin
      bus_rr.pe_datain[1*DW +: DW] = pat(1, s);
      step();
    end
    bus_rr.pe_datain_valid = 4'b0000;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus_rr.m_accept = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus_rr.m_valid) seen = 1'b1;
      step();
    end
    tests_run++;
    if (seen !== 1'b0 || bus_rr.pe_datain_accept !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL reset_midflight: beat_seen=%b accept=%b, required 0 and 1111", seen, bus_rr.pe_datain_accept);
    end
    idle_all();
  endtask

  task automatic test_fixed_priority();
    int seq[4];
    int beats;
    int exp_id;
    int exp_s;
    logic [3:0] acc;
    do_reset();
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      bus_fp.pe_datain[i*DW +: DW] = pat(i, 0);
    end
    bus_fp.pe_datain_valid = 4'b1001;
    bus_fp.m_accept = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = bus_fp.pe_datain_accept & bus_fp.pe_datain_valid;
      if (bus_fp.m_valid) begin
        exp_id = (beats < 6) ? 0 : 3;
        exp_s  = (beats < 6) ? beats : beats - 6;
        tests_run++;
        if (bus_fp.m_pe_id !== 2'(exp_id) || bus_fp.m_data !== pat(exp_id, exp_s)) begin
          tests_failed++;
          $display("[TB] FAIL fp_beat%0d: id=%0d data=%h, required id=%0d data=%h",
                   beats, bus_fp.m_pe_id, bus_fp.m_data, exp_id, pat(exp_id, exp_s));
        end
        beats++;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          seq[i]++;
          bus_fp.pe_datain[i*DW +: DW] = pat(i, seq[i]);
        end
      end
      if (seq[0] == 6) bus_fp.pe_datain_valid[0] = 1'b0;
    end
    tests_run++;
    if (beats != 28) begin
      tests_failed++;
      $display("[TB] FAIL fp_beat_count: got %0d, required 28", beats);
    end
    idle_all();
  endtask

  task automatic test_broadcast();
    logic [63:0] d0;
    logic [63:0] d1;
    logic ok;
    d0 = 64'h1111_2222_3333_4444;
    d1 = 64'hB0B0_C1C1_D2D2_E3E3;
    do_reset();
    bus_rr.s_valid = 1'b1; bus_rr.s_bcast = 1'b0; bus_rr.s_dest = 2'd1; bus_rr.s_data = d0;
    #1;
    tests_run++;
    if (bus_rr.s_accept !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bc_unicast_accept: got %b, required 1", bus_rr.s_accept);
    end
    step();
    bus_rr.s_bcast = 1'b1; bus_rr.s_data = d1;
    #1;
    tests_run++;
    if (bus_rr.s_accept !== 1'b0 || bus_rr.pe_dataout_valid !== 4'b0010 || bus_rr.pe_dataout[1*DW +: DW] !== d0) begin
      tests_failed++;
      $display("[TB] FAIL bc_blocked: s_accept=%b dout_valid=%b data1=%h, required 0/0010/%h",
               bus_rr.s_accept, bus_rr.pe_dataout_valid, bus_rr.pe_dataout[1*DW +: DW], d0);
    end
    step();
    tests_run++;
    if (bus_rr.s_accept !== 1'b0 || bus_rr.pe_dataout_valid !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL bc_still_blocked: s_accept=%b dout_valid=%b, required 0/0010",
               bus_rr.s_accept, bus_rr.pe_dataout_valid);
    end
    bus_rr.pe_dataout_accept = 4'b0010;
    #1;
    tests_run++;
    if (bus_rr.s_accept !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bc_release_accept: got %b, required 1", bus_rr.s_accept);
    end
    step();
    bus_rr.s_valid = 1'b0; bus_rr.pe_dataout_accept = 4'b0000;
    #1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (bus_rr.pe_dataout[i*DW +: DW] !== d1) ok = 1'b0;
    tests_run++;
    if (bus_rr.pe_dataout_valid !== 4'hF || !ok) begin
      tests_failed++;
      $display("[TB] FAIL bc_delivered: dout_valid=%b data=%h, required 1111 with all slices %h",
               bus_rr.pe_dataout_valid, bus_rr.pe_dataout, d1);
    end
    bus_rr.pe_dataout_accept = 4'hF;
    step();
    tests_run++;
    if (bus_rr.pe_dataout_valid !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL bc_cleared: dout_valid=%b, required 0000", bus_rr.pe_dataout_valid);
    end
    bus_rr.pe_dataout_accept = 4'h0;
    bus_rr.s_valid = 1'b1; bus_rr.s_bcast = 1'b0; bus_rr.s_dest = 2'd3; bus_rr.s_data = d0;
    step();
    bus_rr.s_valid = 1'b0;
    tests_run++;
    if (bus_rr.pe_dataout_valid !== 4'b1000 || bus_rr.pe_dataout[3*DW +: DW] !== d0) begin
      tests_failed++;
      $display("[TB] FAIL bc_unicast3: dout_valid=%b data3=%h, required 1000/%h",
               bus_rr.pe_dataout_valid, bus_rr.pe_dataout[3*DW +: DW], d0);
    end
    idle_all();
  endtask

  task automatic test_bad_dest();
    do_reset();
    bus3.s_valid = 1'b1; bus3.s_bcast = 1'b0; bus3.s_dest = 2'd3; bus3.s_data = 64'h77;
    #1;
    tests_run++;
    if (bus3.s_accept !== 1'b1 || bus3.err_bad_dest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bad_accept: s_accept=%b err=%b, required 1/0", bus3.s_accept, bus3.err_bad_dest);
    end
    step();
    bus3.s_valid = 1'b0;
    tests_run++;
    if (bus3.err_bad_dest !== 1'b1 || bus3.pe_dataout_valid !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL bad_flag: err=%b dout_valid=%b, required 1/000", bus3.err_bad_dest, bus3.pe_dataout_valid);
    end
    bus3.s_valid = 1'b1; bus3.s_dest = 2'd2; bus3.s_data = 64'h88;
    step();
    bus3.s_valid = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bus3.err_bad_dest !== 1'b1 || bus3.pe_dataout_valid !== 3'b100 || bus3.pe_dataout[2*DW +: DW] !== 64'h88) begin
      tests_failed++;
      $display("[TB] FAIL bad_sticky: err=%b dout_valid=%b data2=%h, required 1/100/88",
               bus3.err_bad_dest, bus3.pe_dataout_valid, bus3.pe_dataout[2*DW +: DW]);
    end
    do_reset();
    tests_run++;
    if (bus3.err_bad_dest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bad_cleared: err=%b, required 0", bus3.err_bad_dest);
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_reset_midflight();
    test_fixed_priority();
    test_broadcast();
    test_bad_dest();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
